// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB full-speed receive control unit
package usb_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SYNC_RX   = 4'd1,
    ST_PID_RX    = 4'd2,
    ST_DATA_WAIT = 4'd3,
    ST_DATA_RX   = 4'd4,
    ST_DATA_WR   = 4'd5,
    ST_EOP_WAIT  = 4'd6,
    ST_ERR       = 4'd7,
    ST_ERR_IDLE  = 4'd8
  } rx_state_e;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_SYNC = 3'd1;
  localparam logic [2:0] ERR_PID  = 3'd2;
  localparam logic [2:0] ERR_EOP  = 3'd3;
  localparam logic [2:0] ERR_OVF  = 3'd4;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

endpackage

// File: rtl/rx_byte_counter.sv
// rtl/rx_byte_counter.sv - per-packet data byte counter, saturating at MAX_COUNT
module rx_byte_counter #(
  parameter int CNT_W     = 7,
  parameter int MAX_COUNT = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc_o    = (count_q == MAX_C);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (inc_i && !tc_o)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - receive control unit: sync/PID checks, FIFO write strobes, error coding
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic [7:0]       rcv_data,
  input  logic             byte_received,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic [2:0]       err_code,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_done
);

  rx_state_e  state_q, state_d;
  logic       r_error_q, r_error_d;
  logic [2:0] err_code_q, err_code_d;
  logic [3:0] pid_q, pid_d;
  logic       pid_valid_q, pid_valid_d;
  logic       pkt_done_q, pkt_done_d;
  logic       err_eop_q, err_eop_d;
  logic       pkt_start, go_err, cnt_tc, se_eop, pid_ok;
  logic [2:0] err_sel;

  assign se_eop = shift_enable & eop;
  assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);

  rx_byte_counter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (MAX_BYTES)
  ) u_byte_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (pkt_start),
    .inc_i   (state_q == ST_DATA_WR),
    .count_o (byte_count),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    r_error_d   = r_error_q;
    err_code_d  = err_code_q;
    pid_d       = pid_q;
    pid_valid_d = pid_valid_q;
    pkt_done_d  = 1'b0;
    err_eop_d   = err_eop_q;
    pkt_start   = 1'b0;
    go_err      = 1'b0;
    err_sel     = ERR_NONE;
    case (state_q)
      ST_IDLE, ST_ERR_IDLE: begin
        if (d_edge) begin
          state_d     = ST_SYNC_RX;
          pkt_start   = 1'b1;
          r_error_d   = 1'b0;
          err_code_d  = ERR_NONE;
          pid_valid_d = 1'b0;
          err_eop_d   = 1'b0;
        end
      end
      ST_SYNC_RX: begin
        if (se_eop) begin
          go_err  = 1'b1;
          err_sel = ERR_EOP;
        end else if (byte_received) begin
          if (rcv_data == SYNC_BYTE) begin
            state_d = ST_PID_RX;
          end else begin
            go_err  = 1'b1;
            err_sel = ERR_SYNC;
          end
        end
      end
      ST_PID_RX: begin
        if (se_eop) begin
          go_err  = 1'b1;
          err_sel = ERR_EOP;
        end else if (byte_received) begin
          if (pid_ok) begin
            state_d     = ST_DATA_WAIT;
            pid_d       = rcv_data[3:0];
            pid_valid_d = 1'b1;
          end else begin
            go_err  = 1'b1;
            err_sel = ERR_PID;
          end
        end
      end
      ST_DATA_WAIT: begin
        if (shift_enable)
          state_d = eop ? ST_EOP_WAIT : ST_DATA_RX;
      end
      ST_DATA_RX: begin
        if (byte_received) begin
          if (cnt_tc) begin
            go_err  = 1'b1;
            err_sel = ERR_OVF;
          end else begin
            state_d = ST_DATA_WR;
          end
        end else if (se_eop) begin
          go_err  = 1'b1;
          err_sel = ERR_EOP;
        end
      end
      ST_DATA_WR: state_d = ST_DATA_WAIT;
      ST_EOP_WAIT: begin
        if (!eop) begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
        end
      end
      ST_ERR: begin
        // Drain the rest of the packet: first an EOP bit, then the bus leaving SE0.
        if (!err_eop_q) begin
          if (se_eop)
            err_eop_d = 1'b1;
        end else if (!eop) begin
          state_d = ST_ERR_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An error caused by EOP has already seen its EOP bit.
    if (go_err) begin
      state_d    = ST_ERR;
      r_error_d  = 1'b1;
      err_code_d = err_sel;
      err_eop_d  = (err_sel == ERR_EOP);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      r_error_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      pid_q       <= 4'h0;
      pid_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      err_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_error_q   <= r_error_d;
      err_code_q  <= err_code_d;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      pkt_done_q  <= pkt_done_d;
      err_eop_q   <= err_eop_d;
    end
  end

  assign rcving    = (state_q == ST_SYNC_RX) || (state_q == ST_PID_RX) ||
                     (state_q == ST_DATA_WAIT) || (state_q == ST_DATA_RX) ||
                     (state_q == ST_DATA_WR) || (state_q == ST_ERR);
  assign w_enable  = (state_q == ST_DATA_WR);
  assign r_error   = r_error_q;
  assign err_code  = err_code_q;
  assign pid       = pid_q;
  assign pid_valid = pid_valid_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - scoreboard bench for usb_rx_ctrl with directed packets
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;

  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          n_rst, d_edge, eop, shift_enable, byte_received;
  logic [7:0]    rcv_data;
  logic          rcving, w_enable, r_error, pid_valid, pkt_done;
  logic [2:0]    err_code;
  logic [3:0]    pid;
  logic [CW-1:0] byte_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] wq[$];
  int         dq[$];

  usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .rcv_data(rcv_data), .byte_received(byte_received), .rcving(rcving),
    .w_enable(w_enable), .r_error(r_error), .err_code(err_code), .pid(pid),
    .pid_valid(pid_valid), .byte_count(byte_count), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write and every packet-done pulse is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (w_enable) begin
      check("write_expected", int'(wq.size() > 0), 1);
      if (wq.size() > 0) check("write_data", int'(rcv_data), int'(wq.pop_front()));
    end
    if (pkt_done) begin
      check("done_expected", int'(dq.size() > 0), 1);
      if (dq.size() > 0) begin
        int e;
        e = dq.pop_front();
        check("done_pid", int'(pid), e / 256);
        check("done_count", int'(byte_count), e % 256);
        check("done_pid_valid", int'(pid_valid), 1);
        check("done_r_error", int'(r_error), 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    cyc();
    d_edge = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      shift_enable = 1'b1;
      cyc();
      shift_enable = 1'b0;
      if (i == 7) begin
        rcv_data      = d;
        byte_received = 1'b1;
        cyc();
        byte_received = 1'b0;
        idle(2);
      end else begin
        idle(3);
      end
    end
  endtask

  task automatic send_eop();
    for (int i = 0; i < 2; i++) begin
      eop          = 1'b1;
      shift_enable = 1'b1;
      cyc();
      shift_enable = 1'b0;
      idle(3);
    end
    eop = 1'b0;
    cyc();
    idle(2);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rcving"}, int'(rcving), 0);
    check({tag, "_w_enable"}, int'(w_enable), 0);
    check({tag, "_r_error"}, int'(r_error), 0);
    check({tag, "_pid_valid"}, int'(pid_valid), 0);
    check({tag, "_pkt_done"}, int'(pkt_done), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_pid"}, int'(pid), 0);
    check({tag, "_byte_count"}, int'(byte_count), 0);
  endtask

  task automatic clean_packet(input string tag, input logic [7:0] pid_byte,
                              input logic [7:0] base, input int n);
    start_pkt();
    check({tag, "_rcving_after_edge"}, int'(rcving), 1);
    send_byte(8'h80, 8);
    send_byte(pid_byte, 8);
    for (int i = 0; i < n; i++) begin
      wq.push_back(base + 8'(i));
      send_byte(base + 8'(i), 8);
    end
    dq.push_back(int'(pid_byte[3:0]) * 256 + n);
    send_eop();
    check({tag, "_rcving"}, int'(rcving), 0);
    check({tag, "_r_error"}, int'(r_error), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_pid"}, int'(pid), int'(pid_byte[3:0]));
    check({tag, "_pid_valid"}, int'(pid_valid), 1);
    check({tag, "_byte_count"}, int'(byte_count), n);
  endtask

  initial begin
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00;
    idle(2);
    check_reset("reset");
    n_rst = 1'b1;
    cyc();

    clean_packet("clean", 8'hE1, 8'h10, 3);
    check("clean_scoreboard", wq.size() + dq.size(), 0);

    // Bad sync byte
    pulse_reset();
    start_pkt();
    send_byte(8'h54, 8);
    check("badsync_r_error", int'(r_error), 1);
    check("badsync_err_code", int'(err_code), int'(ERR_SYNC));
    check("badsync_rcving", int'(rcving), 1);
    send_eop();
    check("badsync_erridle_rcving", int'(rcving), 0);
    check("badsync_erridle_r_error", int'(r_error), 1);
    start_pkt();
    check("badsync_cleared_r_error", int'(r_error), 0);
    check("badsync_cleared_err_code", int'(err_code), 0);

    // Failed PID check nibble
    pulse_reset();
    start_pkt();
    send_byte(8'h80, 8);
    send_byte(8'hF1, 8);
    check("badpid_err_code", int'(err_code), int'(ERR_PID));
    check("badpid_pid_valid", int'(pid_valid), 0);
    check("badpid_r_error", int'(r_error), 1);
    send_eop();
    check("badpid_byte_count", int'(byte_count), 0);

    // EOP three bits into the second data byte
    pulse_reset();
    start_pkt();
    send_byte(8'h80, 8);
    send_byte(8'hE1, 8);
    wq.push_back(8'h21);
    send_byte(8'h21, 8);
    send_byte(8'h22, 3);
    send_eop();
    check("eop_err_code", int'(err_code), int'(ERR_EOP));
    check("eop_r_error", int'(r_error), 1);
    check("eop_erridle_rcving", int'(rcving), 0);
    check("eop_byte_count", int'(byte_count), 1);
    check("eop_scoreboard", wq.size(), 0);

    // Overflow: five bytes into a four-byte packet limit
    pulse_reset();
    start_pkt();
    send_byte(8'h80, 8);
    send_byte(8'hE1, 8);
    for (int i = 0; i < 5; i++) begin
      if (i < MAXB) wq.push_back(8'h40 + 8'(i));
      send_byte(8'h40 + 8'(i), 8);
    end
    check("ovf_err_code", int'(err_code), int'(ERR_OVF));
    check("ovf_byte_count", int'(byte_count), MAXB);
    check("ovf_r_error", int'(r_error), 1);
    send_eop();
    check("ovf_rcving", int'(rcving), 0);
    check("ovf_scoreboard", wq.size(), 0);

    // Reset between the second data byte_received and its write
    pulse_reset();
    start_pkt();
    send_byte(8'h80, 8);
    send_byte(8'hE1, 8);
    wq.push_back(8'h31);
    send_byte(8'h31, 8);
    send_byte(8'h32, 7);
    shift_enable = 1'b1;
    cyc();
    shift_enable  = 1'b0;
    rcv_data      = 8'h32;
    byte_received = 1'b1;
    n_rst         = 1'b0;
    #1;
    check_reset("midrst_async");
    cyc();
    byte_received = 1'b0;
    check_reset("midrst_held");
    n_rst = 1'b1;
    idle(2);
    check("midrst_scoreboard", wq.size(), 0);
    clean_packet("after_rst", 8'hA5, 8'h50, 2);
    check("final_scoreboard", wq.size() + dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
